// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port synchronous memory with a one-cycle registered read.
// Read latency is absorbed in a 2-entry skid buffer so bursts sustain one word per clock.
//
// state | meaning
// IDLE  | waiting for a command; zero-length commands complete here
// WRITE | accepting write beats straight into memory
// READ  | issuing reads while buffer + in-flight stay within two words
// DRAIN | all reads issued; waiting for the last words to be popped
module mem_burst_master #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic             cmdWrite,
  input  logic [DEPTH-1:0] cmdAddress,
  input  logic [DEPTH:0]   cmdLength,
  input  logic             wrValid,
  output logic             wrReady,
  input  logic [WIDTH-1:0] wrData,
  output logic             rdValid,
  input  logic             rdReady,
  output logic [WIDTH-1:0] rdData,
  output logic             busy,
  output logic             done,
  output logic             memWriteEnable,
  output logic [DEPTH-1:0] memAddress,
  output logic [WIDTH-1:0] memWriteData,
  input  logic [WIDTH-1:0] memReadData
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t           state, state_next;
  logic [DEPTH-1:0] ptr;
  logic [DEPTH:0]   remaining;
  logic             in_flight;
  logic             done_q;
  logic [WIDTH-1:0] skid [2];
  logic             head, tail;
  logic [1:0]       entries;
  logic [1:0]       occupancy;
  logic             accept, beat, issue, pop, finish, last_word;

  assign accept    = (state == IDLE) && cmdValid;
  assign beat      = (state == WRITE) && wrValid;
  assign pop       = (entries != 2'd0) && rdReady;
  assign occupancy = entries + {1'b0, in_flight};
  assign last_word = (remaining == (DEPTH+1)'(1));

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (cmdValid) begin
          if (cmdLength == '0) finish     = 1'b1;
          else if (cmdWrite)   state_next = WRITE;
          else                 state_next = READ;
        end
      end
      WRITE: begin
        if (wrValid && last_word) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
      READ: begin
        // A pop in the same cycle frees a slot, so issue need not wait a cycle.
        issue = (occupancy < 2'd2) || ((occupancy == 2'd2) && pop);
        if (issue && last_word) state_next = DRAIN;
      end
      DRAIN: begin
        if (!in_flight && ((entries == 2'd0) || ((entries == 2'd1) && pop))) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      ptr       <= '0;
      remaining <= '0;
      in_flight <= 1'b0;
      done_q    <= 1'b0;
      head      <= 1'b0;
      tail      <= 1'b0;
      entries   <= 2'd0;
      skid[0]   <= '0;
      skid[1]   <= '0;
    end else begin
      done_q    <= finish;
      in_flight <= issue;
      if (accept) begin
        ptr       <= cmdAddress;
        remaining <= cmdLength;
      end else if (beat || issue) begin
        ptr       <= ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (in_flight) begin
        skid[tail] <= memReadData;
        tail       <= ~tail;
      end
      if (pop) head <= ~head;
      entries <= entries + {1'b0, in_flight} - {1'b0, pop};
    end
  end

  assign cmdReady       = (state == IDLE);
  assign busy           = (state != IDLE);
  assign wrReady        = (state == WRITE);
  assign done           = done_q;
  assign memWriteEnable = beat;
  assign memAddress     = ptr;
  assign memWriteData   = (state == WRITE) ? wrData : '0;
  assign rdValid        = (entries != 2'd0);
  assign rdData         = skid[head];

endmodule

// File: tb/tb_mem_burst_master.sv
// Self-checking bench for mem_burst_master: a registered-read memory model drives the DUT and
// an array of expected memory contents predicts every written address and every read beat.
module tb_mem_burst_master;

  logic       clock, resetN;
  logic       cmdValid, cmdReady, cmdWrite;
  logic [3:0] cmdAddress;
  logic [4:0] cmdLength;
  logic       wrValid, wrReady;
  logic [7:0] wrData;
  logic       rdValid, rdReady;
  logic [7:0] rdData;
  logic       busy, done, memWriteEnable;
  logic [3:0] memAddress;
  logic [7:0] memWriteData, memReadData;

  int checks = 0;
  int errors = 0;

  logic [7:0] env_mem [16];
  logic       env_init = 1'b0;
  logic [7:0] model_mem [16];

  mem_burst_master #(.DEPTH(4), .WIDTH(8)) dut (
    .clock(clock), .resetN(resetN),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
    .cmdAddress(cmdAddress), .cmdLength(cmdLength),
    .wrValid(wrValid), .wrReady(wrReady), .wrData(wrData),
    .rdValid(rdValid), .rdReady(rdReady), .rdData(rdData),
    .busy(busy), .done(done),
    .memWriteEnable(memWriteEnable), .memAddress(memAddress),
    .memWriteData(memWriteData), .memReadData(memReadData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port memory with registered read; contents survive the DUT reset.
  always @(posedge clock) begin
    if (!env_init) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= 8'h50 + 8'(i);
      env_init <= 1'b1;
    end else if (memWriteEnable) begin
      env_mem[memAddress] <= memWriteData;
    end
    memReadData <= env_mem[memAddress];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_cmdReady"}, 32'(cmdReady), 1);
    chk({p, "_busy"}, 32'(busy), 0);
    chk({p, "_done"}, 32'(done), 0);
    chk({p, "_wrReady"}, 32'(wrReady), 0);
    chk({p, "_rdValid"}, 32'(rdValid), 0);
    chk({p, "_rdData"}, 32'(rdData), 0);
    chk({p, "_memWriteEnable"}, 32'(memWriteEnable), 0);
    chk({p, "_memAddress"}, 32'(memAddress), 0);
    chk({p, "_memWriteData"}, 32'(memWriteData), 0);
  endtask

  task automatic do_write(input int base, input logic [7:0] data [$], input int gap_pct);
    int len = data.size();
    int i = 0;
    int cyc = 0;
    @(negedge clock);
    cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddress = 4'(base); cmdLength = 5'(len);
    #1 chk("wr_accept_ready", 32'(cmdReady), 1);
    chk("wr_accept_nowrite", 32'(memWriteEnable), 0);
    @(negedge clock);
    cmdValid = 1'b0;
    while (i < len && cyc < 200) begin
      wrValid = ($urandom_range(0, 99) >= gap_pct);
      wrData  = wrValid ? data[i] : 8'($urandom);
      #1;
      chk("wr_busy", 32'(busy), 1);
      chk("wr_ready", 32'(wrReady), 1);
      chk("wr_done_low", 32'(done), 0);
      chk("wr_we", 32'(memWriteEnable), 32'(wrValid));
      if (wrValid) begin
        chk("wr_addr", 32'(memAddress), 32'((base + i) % 16));
        chk("wr_data", 32'(memWriteData), 32'(data[i]));
        model_mem[(base + i) % 16] = data[i];
        i++;
      end
      cyc++;
      @(negedge clock);
    end
    wrValid = 1'b0;
    if (i < len) chk("wr_timeout", 32'(i), 32'(len));
    if (gap_pct == 0) chk("wr_cycles", 32'(cyc), 32'(len));
    #1;
    chk("wr_done", 32'(done), 1);
    chk("wr_idle_busy", 32'(busy), 0);
    chk("wr_idle_cmdready", 32'(cmdReady), 1);
    chk("wr_idle_wrready", 32'(wrReady), 0);
    @(negedge clock);
    #1 chk("wr_done_pulse", 32'(done), 0);
  endtask

  // mode 0: rdReady always high; 1: repeating 1,0,0,1; 2: random
  task automatic do_read(input int base, input int len, input int mode);
    int cyc = 1;
    int popped = 0;
    int issued;
    logic [3:0] diff;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [3:0] pattern = 4'b1001;
    @(negedge clock);
    cmdValid = 1'b1; cmdWrite = 1'b0; cmdAddress = 4'(base); cmdLength = 5'(len); rdReady = 1'b0;
    #1 chk("rd_accept_ready", 32'(cmdReady), 1);
    @(negedge clock);
    cmdValid = 1'b0;
    while (popped < len && cyc < 300) begin
      rdReady = (mode == 0) ? 1'b1 : (mode == 1) ? pattern[(cyc - 1) % 4] : 1'($urandom_range(0, 1));
      #1;
      chk("rd_busy", 32'(busy), 1);
      chk("rd_done_low", 32'(done), 0);
      chk("rd_no_write", 32'(memWriteEnable), 0);
      if (cyc <= 2) chk("rd_latency_low", 32'(rdValid), 0);
      if (cyc == 3) chk("rd_latency_high", 32'(rdValid), 1);
      if (prev_stall) begin
        chk("rd_hold_valid", 32'(rdValid), 1);
        chk("rd_hold_data", 32'(rdData), 32'(prev_data));
      end
      if (len < 16) begin
        diff = memAddress - 4'(base);
        issued = int'(diff);
        chk("rd_outstanding", 32'(issued - popped <= 2), 1);
      end
      if (rdValid && rdReady) begin
        chk("rd_data", 32'(rdData), 32'(model_mem[(base + popped) % 16]));
        popped++;
        if (mode == 0 && popped == len) chk("rd_last_cycle", 32'(cyc), 32'(len + 2));
      end
      prev_stall = rdValid && !rdReady;
      prev_data  = rdData;
      cyc++;
      @(negedge clock);
    end
    rdReady = 1'b0;
    if (popped < len) chk("rd_timeout", 32'(popped), 32'(len));
    #1;
    chk("rd_done", 32'(done), 1);
    chk("rd_idle_busy", 32'(busy), 0);
    chk("rd_idle_valid", 32'(rdValid), 0);
    chk("rd_idle_cmdready", 32'(cmdReady), 1);
    @(negedge clock);
    #1 chk("rd_done_pulse", 32'(done), 0);
  endtask

  task automatic do_zero(input logic wr);
    @(negedge clock);
    cmdValid = 1'b1; cmdWrite = wr; cmdAddress = 4'($urandom); cmdLength = 5'd0;
    wrValid = 1'b1; rdReady = 1'b1;
    #1 chk("zero_accept_ready", 32'(cmdReady), 1);
    @(negedge clock);
    cmdValid = 1'b0;
    #1;
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_we", 32'(memWriteEnable), 0);
    chk("zero_rdvalid", 32'(rdValid), 0);
    @(negedge clock);
    #1;
    chk("zero_done_pulse", 32'(done), 0);
    chk("zero_rdvalid_after", 32'(rdValid), 0);
    wrValid = 1'b0; rdReady = 1'b0;
  endtask

  initial begin
    logic [7:0] q [$];
    logic [7:0] d0, d1;
    int base, len;

    for (int i = 0; i < 16; i++) model_mem[i] = 8'h50 + 8'(i);
    resetN = 1'b0; cmdValid = 1'b0; cmdWrite = 1'b0; cmdAddress = '0; cmdLength = '0;
    wrValid = 1'b0; wrData = '0; rdReady = 1'b0;
    #2 chk_reset("por");
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    #1;
    chk("rel_cmdReady", 32'(cmdReady), 1);
    chk("rel_busy", 32'(busy), 0);

    q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    do_write(3, q, 0);
    do_read(3, 4, 0);

    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(14, q, 0);
    do_read(14, 4, 0);

    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    do_write(5, q, 0);
    do_read(5, 8, 1);

    do_zero(1'b1);
    do_zero(1'b0);

    // Write of 3 with a gap, aborted by reset after the second beat.
    d0 = 8'($urandom); d1 = 8'($urandom);
    @(negedge clock);
    cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddress = 4'd9; cmdLength = 5'd3;
    @(negedge clock);
    cmdValid = 1'b0; wrValid = 1'b1; wrData = d0;
    #1 chk("abort_beat0_addr", 32'(memAddress), 9);
    model_mem[9] = d0;
    @(negedge clock);
    wrValid = 1'b0;
    #1 chk("abort_gap_we", 32'(memWriteEnable), 0);
    @(negedge clock);
    wrValid = 1'b1; wrData = d1;
    #1 chk("abort_beat1_addr", 32'(memAddress), 10);
    model_mem[10] = d1;
    @(negedge clock);
    wrValid = 1'b1; wrData = ~d1;
    #1 chk("abort_pre_we", 32'(memWriteEnable), 1);
    #2 resetN = 1'b0;
    #1 chk_reset("abort");
    @(negedge clock);
    wrValid = 1'b0;
    #1 chk("abort_no_done", 32'(done), 0);
    resetN = 1'b1;
    @(negedge clock);
    #1;
    chk("abort_no_done_after", 32'(done), 0);
    chk("abort_idle", 32'(cmdReady), 1);
    do_read(9, 3, 0);

    for (int r = 0; r < 6; r++) begin
      base = $urandom_range(0, 15);
      len  = $urandom_range(1, 16);
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      do_write(base, q, 30);
      do_read(base, len, 2);
    end
    do_zero(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
